// File: rtl/ascon_pack.sv
// -----------------------------------------------------------------------------
// ascon_pack
//   Shared types and constants for the ASCON-128a decryption datapath.
//   type_state   : five 64-bit lanes, index 0 = S0 ... index 4 = S4
//   IV_128A      : ASCON-128a initialisation vector (S0 at load time)
//   PAD_128A     : padding word for the empty final message block
//   DSEP         : domain-separation bit xored into S4 after the AD phase
//   dec_state_t  : decryption FSM states
//   rotr64       : 64-bit rotate right, used by the linear layer
// -----------------------------------------------------------------------------
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [63:0] IV_128A  = 64'h80800C0800000000;
    localparam logic [63:0] PAD_128A = 64'h8000000000000000;
    localparam logic [63:0] DSEP     = 64'h0000000000000001;

    // p12 runs rounds 0..11, p8 runs rounds 4..11
    localparam logic [3:0] RND_P12_FIRST = 4'd0;
    localparam logic [3:0] RND_P8_FIRST  = 4'd4;
    localparam logic [3:0] RND_LAST      = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ASSOC,
        ST_CWAIT,
        ST_CPERM,
        ST_FINAL,
        ST_DONE
    } dec_state_t;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/addition_constante.sv
// -----------------------------------------------------------------------------
// addition_constante
//   Round-constant layer: S2[7:0] ^= {~r, r} where r is the round index 0..11.
//   i_state  : state entering the round
//   i_round  : round index
//   o_state  : state with the constant applied
// -----------------------------------------------------------------------------
module addition_constante
    import ascon_pack::*;
(
    input  type_state  i_state,
    input  logic [3:0] i_round,
    output type_state  o_state
);

    logic [7:0] w_const;

    // 0xF0 for round 0 down to 0x4B for round 11
    assign w_const = {4'hF - i_round, i_round};

    always_comb begin
        o_state       = i_state;
        o_state[2][7:0] = i_state[2][7:0] ^ w_const;
    end

endmodule

// File: rtl/couche_substitution.sv
// -----------------------------------------------------------------------------
// couche_substitution
//   5-bit ASCON S-box applied to all 64 bit-columns in parallel (bitsliced).
//   i_state : state after constant addition
//   o_state : state after substitution
// -----------------------------------------------------------------------------
module couche_substitution
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic [63:0] w_y0, w_y1, w_y2, w_y3, w_y4;

    assign w_x0 = i_state[0] ^ i_state[4];
    assign w_x1 = i_state[1];
    assign w_x2 = i_state[2] ^ i_state[1];
    assign w_x3 = i_state[3];
    assign w_x4 = i_state[4] ^ i_state[3];

    // chi-like nonlinear step
    assign w_t0 = ~w_x0 & w_x1;
    assign w_t1 = ~w_x1 & w_x2;
    assign w_t2 = ~w_x2 & w_x3;
    assign w_t3 = ~w_x3 & w_x4;
    assign w_t4 = ~w_x4 & w_x0;

    assign w_y0 = w_x0 ^ w_t1;
    assign w_y1 = w_x1 ^ w_t2;
    assign w_y2 = w_x2 ^ w_t3;
    assign w_y3 = w_x3 ^ w_t4;
    assign w_y4 = w_x4 ^ w_t0;

    assign o_state[0] = w_y0 ^ w_y4;
    assign o_state[1] = w_y1 ^ w_y0;
    assign o_state[2] = ~w_y2;
    assign o_state[3] = w_y3 ^ w_y2;
    assign o_state[4] = w_y4;

endmodule

// File: rtl/diffusion_lineaire.sv
// -----------------------------------------------------------------------------
// diffusion_lineaire
//   Per-lane linear diffusion: Si ^= (Si >>> a) ^ (Si >>> b).
//   i_state : state after substitution
//   o_state : state at the end of the round
// -----------------------------------------------------------------------------
module diffusion_lineaire
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    assign o_state[0] = i_state[0] ^ rotr64(i_state[0], 19) ^ rotr64(i_state[0], 28);
    assign o_state[1] = i_state[1] ^ rotr64(i_state[1], 61) ^ rotr64(i_state[1], 39);
    assign o_state[2] = i_state[2] ^ rotr64(i_state[2],  1) ^ rotr64(i_state[2],  6);
    assign o_state[3] = i_state[3] ^ rotr64(i_state[3], 10) ^ rotr64(i_state[3], 17);
    assign o_state[4] = i_state[4] ^ rotr64(i_state[4],  7) ^ rotr64(i_state[4], 41);

endmodule

// File: rtl/permutation_xor_dec.sv
// -----------------------------------------------------------------------------
// permutation_xor_dec
//   ASCON state register with one round per update and the decrypt-side
//   xor layers around it.
//   Update order within one cycle:
//     xor up (S0,S1 replaced or xored) -> pad S0 -> pre-key S2,S3
//     -> optional round -> post-key S3,S4 -> domain separation S4
//   i_clock, i_reset      : clock, async active-high reset (state cleared)
//   i_load / i_load_state : load a fresh state (priority over i_en)
//   i_en                  : commit the updated state this cycle
//   i_round_en / i_round  : apply one permutation round with this index
//   i_xup_en/_replace/_data : S0,S1 <= data (replace) or S0,S1 ^= data
//   i_pad                 : S0 ^= PAD_128A
//   i_key_pre             : S2,S3 ^= K before the round
//   i_key_post            : S3,S4 ^= K after the round
//   i_dsep                : S4 ^= DSEP after the round
//   i_key                 : 128-bit key
//   o_s01, o_s34          : {S0,S1} and {S3,S4} of the registered state
// -----------------------------------------------------------------------------
module permutation_xor_dec
    import ascon_pack::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  type_state    i_load_state,
    input  logic         i_en,
    input  logic         i_round_en,
    input  logic [3:0]   i_round,
    input  logic         i_xup_en,
    input  logic         i_xup_replace,
    input  logic [127:0] i_xup_data,
    input  logic         i_pad,
    input  logic         i_key_pre,
    input  logic         i_key_post,
    input  logic         i_dsep,
    input  logic [127:0] i_key,
    output logic [127:0] o_s01,
    output logic [127:0] o_s34
);

    type_state r_s;
    type_state w_pre, w_pc, w_ps, w_pl, w_post;

    always_comb begin
        w_pre = r_s;
        if (i_xup_en) begin
            if (i_xup_replace) {w_pre[0], w_pre[1]} = i_xup_data;
            else               {w_pre[0], w_pre[1]} = {r_s[0], r_s[1]} ^ i_xup_data;
        end
        if (i_pad) w_pre[0] = w_pre[0] ^ PAD_128A;
        if (i_key_pre) begin
            w_pre[2] = w_pre[2] ^ i_key[127:64];
            w_pre[3] = w_pre[3] ^ i_key[63:0];
        end
    end

    addition_constante  u_pc (.i_state(w_pre), .i_round(i_round), .o_state(w_pc));
    couche_substitution u_ps (.i_state(w_pc),  .o_state(w_ps));
    diffusion_lineaire  u_pl (.i_state(w_ps),  .o_state(w_pl));

    always_comb begin
        w_post = i_round_en ? w_pl : w_pre;
        if (i_key_post) begin
            w_post[3] = w_post[3] ^ i_key[127:64];
            w_post[4] = w_post[4] ^ i_key[63:0];
        end
        if (i_dsep) w_post[4] = w_post[4] ^ DSEP;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)     r_s <= '0;
        else if (i_load) r_s <= i_load_state;
        else if (i_en)   r_s <= w_post;
    end

    assign o_s01 = {r_s[0], r_s[1]};
    assign o_s34 = {r_s[3], r_s[4]};

endmodule

// File: rtl/ascon_decrypt_top.sv
// -----------------------------------------------------------------------------
// ascon_decrypt_top
//   ASCON-128a authenticated decryption: key/nonce init, one AD block,
//   NB_BLOCKS ciphertext blocks, tag recomputation and comparison.
//   One permutation round per clock. Plaintext is released before the tag is
//   checked; the host drops the message if done_o comes with tag_ok_o = 0.
//   clock_i, reset_i  : clock, async active-high reset
//   start_i           : start pulse, honoured only when idle
//   key_i, nonce_i    : key (stable until done_o), nonce (sampled at start)
//   ad_i              : padded associated-data block
//   tag_i             : received tag, compared on the done cycle
//   cipher_i/_valid_i, cipher_ready_o : ciphertext handshake
//   plain_o, plain_valid_o : plaintext block and its one-cycle strobe
//   busy_o, done_o, tag_ok_o : status
// -----------------------------------------------------------------------------
module ascon_decrypt_top
    import ascon_pack::*;
#(
    parameter int NB_BLOCKS = 4
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] ad_i,
    input  logic [127:0] tag_i,
    input  logic [127:0] cipher_i,
    input  logic         cipher_valid_i,
    output logic         cipher_ready_o,
    output logic [127:0] plain_o,
    output logic         plain_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
);

    // the 4-bit block counter must not wrap
    generate
        if (NB_BLOCKS < 1 || NB_BLOCKS > 15) begin : g_bad_nb_blocks
            $error("ascon_decrypt_top: NB_BLOCKS must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAST_BLK = 4'(NB_BLOCKS - 1);

    dec_state_t   r_fsm;
    logic [3:0]   r_round;
    logic [3:0]   r_blk;
    logic         r_ready, r_pvalid, r_busy, r_done, r_tag_ok;
    logic [127:0] r_plain;

    type_state    w_init;
    logic [127:0] w_s01, w_s34, w_xup_data;
    logic         w_load, w_accept, w_last_blk, w_en, w_round_en;
    logic         w_xup_en, w_pad, w_key_pre, w_key_post, w_dsep;

    always_comb begin
        w_init    = '0;
        w_init[0] = IV_128A;
        w_init[1] = key_i[127:64];
        w_init[2] = key_i[63:0];
        w_init[3] = nonce_i[127:64];
        w_init[4] = nonce_i[63:0];
    end

    assign w_load     = (r_fsm == ST_IDLE) && start_i;
    assign w_accept   = (r_fsm == ST_CWAIT) && r_ready && cipher_valid_i;
    assign w_last_blk = (r_blk == LAST_BLK);
    assign w_round_en = (r_fsm == ST_INIT) || (r_fsm == ST_ASSOC) ||
                        (r_fsm == ST_CPERM) || (r_fsm == ST_FINAL);
    assign w_en       = w_round_en || w_accept;

    // AD xor on the first ASSOC round; ciphertext replaces S0,S1 on acceptance
    assign w_xup_en   = w_accept || ((r_fsm == ST_ASSOC) && (r_round == RND_P8_FIRST));
    assign w_xup_data = w_accept ? cipher_i : ad_i;
    // full-block messages end with an empty padded block, folded into the last acceptance
    assign w_pad      = w_accept && w_last_blk;
    assign w_key_pre  = (r_fsm == ST_FINAL) && (r_round == RND_P12_FIRST);
    assign w_key_post = ((r_fsm == ST_INIT) || (r_fsm == ST_FINAL)) && (r_round == RND_LAST);
    assign w_dsep     = (r_fsm == ST_ASSOC) && (r_round == RND_LAST);

    permutation_xor_dec u_perm (
        .i_clock       (clock_i),
        .i_reset       (reset_i),
        .i_load        (w_load),
        .i_load_state  (w_init),
        .i_en          (w_en),
        .i_round_en    (w_round_en),
        .i_round       (r_round),
        .i_xup_en      (w_xup_en),
        .i_xup_replace (w_accept),
        .i_xup_data    (w_xup_data),
        .i_pad         (w_pad),
        .i_key_pre     (w_key_pre),
        .i_key_post    (w_key_post),
        .i_dsep        (w_dsep),
        .i_key         (key_i),
        .o_s01         (w_s01),
        .o_s34         (w_s34)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm    <= ST_IDLE;
            r_round  <= '0;
            r_blk    <= '0;
            r_ready  <= 1'b0;
            r_pvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tag_ok <= 1'b0;
            r_plain  <= '0;
        end else begin
            r_pvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start_i) begin
                        r_fsm    <= ST_INIT;
                        r_round  <= RND_P12_FIRST;
                        r_blk    <= '0;
                        r_busy   <= 1'b1;
                        r_tag_ok <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_round <= r_round + 4'd1;
                    if (r_round == RND_LAST) begin
                        r_fsm   <= ST_ASSOC;
                        r_round <= RND_P8_FIRST;
                    end
                end
                ST_ASSOC: begin
                    r_round <= r_round + 4'd1;
                    if (r_round == RND_LAST) begin
                        r_fsm   <= ST_CWAIT;
                        r_ready <= 1'b1;
                    end
                end
                ST_CWAIT: begin
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_plain  <= w_s01 ^ cipher_i;
                        r_pvalid <= 1'b1;
                        r_blk    <= r_blk + 4'd1;
                        if (w_last_blk) begin
                            r_fsm   <= ST_FINAL;
                            r_round <= RND_P12_FIRST;
                        end else begin
                            r_fsm   <= ST_CPERM;
                            r_round <= RND_P8_FIRST;
                        end
                    end
                end
                ST_CPERM: begin
                    r_round <= r_round + 4'd1;
                    if (r_round == RND_LAST) begin
                        r_fsm   <= ST_CWAIT;
                        r_ready <= 1'b1;
                    end
                end
                ST_FINAL: begin
                    r_round <= r_round + 4'd1;
                    if (r_round == RND_LAST) r_fsm <= ST_DONE;
                end
                ST_DONE: begin
                    r_tag_ok <= (w_s34 == tag_i);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_fsm    <= ST_IDLE;
                end
                default: begin
                    r_fsm   <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cipher_ready_o = r_ready;
    assign plain_o        = r_plain;
    assign plain_valid_o  = r_pvalid;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign tag_ok_o       = r_tag_ok;

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// -----------------------------------------------------------------------------
// tb_ascon_decrypt_top
//   Scoreboard bench: each message pushes its expected plaintext blocks and
//   tag verdict into queues; a negedge monitor pops and compares whenever the
//   DUT strobes plain_valid_o or done_o. Ciphertext and tag are produced by a
//   table-driven ASCON model acting as the encryption side.
// -----------------------------------------------------------------------------
module tb_ascon_decrypt_top;

    localparam int NB = 2;
    typedef logic [4:0][63:0] st_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0, nonce_i = '0, ad_i = '0, tag_i = '0, cipher_i = '0;
    logic         cipher_valid_i = 1'b0;
    logic         cipher_ready_o, plain_valid_o, busy_o, done_o, tag_ok_o;
    logic [127:0] plain_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [127:0] exp_plain_q[$];
    logic         exp_ok_q[$];
    logic [127:0] pt [NB];
    logic [127:0] ct [NB];
    logic [127:0] tag_m;

    logic [4:0] sbox [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    ascon_decrypt_top #(.NB_BLOCKS(NB)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start_i),
        .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .tag_i(tag_i),
        .cipher_i(cipher_i), .cipher_valid_i(cipher_valid_i),
        .cipher_ready_o(cipher_ready_o), .plain_o(plain_o),
        .plain_valid_o(plain_valid_o), .busy_o(busy_o), .done_o(done_o),
        .tag_ok_o(tag_ok_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event/timeout, required none", name);
    endtask

    // ---------------- model (encryption side) ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t m_round(input st_t s, input int r);
        st_t t;
        logic [4:0] y;
        s[2][7:0] = s[2][7:0] ^ 8'((15 - r) * 16 + r);
        for (int b = 0; b < 64; b++) begin
            y = sbox[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
            t[0][b] = y[4]; t[1][b] = y[3]; t[2][b] = y[2]; t[3][b] = y[1]; t[4][b] = y[0];
        end
        s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
        s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
        s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
        s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
        s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        return s;
    endfunction

    function automatic st_t m_perm(input st_t s, input int first);
        for (int r = first; r < 12; r++) s = m_round(s, r);
        return s;
    endfunction

    task automatic model_enc();
        st_t s;
        logic [127:0] c;
        s[0] = 64'h80800C0800000000;
        s[1] = key_i[127:64];   s[2] = key_i[63:0];
        s[3] = nonce_i[127:64]; s[4] = nonce_i[63:0];
        s = m_perm(s, 0);
        s[3] = s[3] ^ key_i[127:64]; s[4] = s[4] ^ key_i[63:0];
        s[0] = s[0] ^ ad_i[127:64];  s[1] = s[1] ^ ad_i[63:0];
        s = m_perm(s, 4);
        s[4] = s[4] ^ 64'h1;
        for (int b = 0; b < NB; b++) begin
            c = {s[0], s[1]} ^ pt[b];
            ct[b] = c;
            s[0] = c[127:64]; s[1] = c[63:0];
            if (b < NB - 1) s = m_perm(s, 4);
            else            s[0] = s[0] ^ 64'h8000000000000000;
        end
        s[2] = s[2] ^ key_i[127:64]; s[3] = s[3] ^ key_i[63:0];
        s = m_perm(s, 0);
        s[3] = s[3] ^ key_i[127:64]; s[4] = s[4] ^ key_i[63:0];
        tag_m = {s[3], s[4]};
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (plain_valid_o) begin
            if (exp_plain_q.size() == 0) fail_evt("unexpected_plain_valid");
            else chk("plain_block", plain_o, exp_plain_q.pop_front());
        end
        if (done_o) begin
            if (exp_ok_q.size() == 0) fail_evt("unexpected_done");
            else chk("tag_ok", 128'(tag_ok_o), 128'(exp_ok_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    // Starts a message and waits until cipher_ready_o first rises.
    task automatic start_msg(input bit glitch, output int t0, output bit ok);
        @(posedge clk); #1 start_i = 1'b1; t0 = cyc;
        @(posedge clk); #1 start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_i = glitch && (i == 3);
            if (cipher_ready_o) begin ok = 1'b1; break; end
        end
        start_i = 1'b0;
        if (!ok) fail_evt("ready_timeout");
    endtask

    // Offers ct[b] and returns the cycle in which it is accepted.
    task automatic send_block(input int b, output int acc, output bit ok);
        cipher_i = ct[b];
        cipher_valid_i = 1'b1;
        ok = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (cipher_ready_o) begin ok = 1'b1; acc = cyc; break; end
            @(negedge clk);
        end
        if (!ok) fail_evt("accept_timeout");
    endtask

    task automatic run_msg(input bit flip, input int bp, input bit glitch);
        int t0, acc, acc_prev, tdone;
        bit ok;
        model_enc();
        tag_i = tag_m ^ {127'b0, flip};
        for (int b = 0; b < NB; b++) exp_plain_q.push_back(pt[b]);
        exp_ok_q.push_back(!flip);
        cipher_valid_i = (bp == 0);
        cipher_i = ct[0];
        start_msg(glitch, t0, ok);
        if (!ok) return;
        chk("ready_latency", 128'(cyc - t0), 128'(21));
        chk("busy_in_cwait", 128'(busy_o), 128'(1));
        if (bp > 0) begin
            repeat (bp) @(negedge clk);
            chk("ready_held_under_backpressure", 128'(cipher_ready_o), 128'(1));
        end
        acc_prev = 0;
        for (int b = 0; b < NB; b++) begin
            if (b > 0) @(negedge clk);
            send_block(b, acc, ok);
            if (!ok) return;
            if (b > 0) chk("block_interval", 128'(acc - acc_prev), 128'(9));
            acc_prev = acc;
        end
        ok = 1'b0;
        tdone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cipher_valid_i = 1'b0;
            start_i = glitch && (i == 4);
            if (done_o) begin ok = 1'b1; tdone = cyc; break; end
        end
        start_i = 1'b0;
        if (!ok) begin fail_evt("done_timeout"); return; end
        chk("done_latency", 128'(tdone - acc), 128'(14));
        @(negedge clk);
        chk("busy_after_done", 128'(busy_o), 128'(0));
        chk("tag_ok_held", 128'(tag_ok_o), 128'(!flip));
        repeat (30) @(negedge clk);
        chk("plain_queue_drained", 128'(exp_plain_q.size()), 128'(0));
        chk("done_queue_drained", 128'(exp_ok_q.size()), 128'(0));
    endtask

    initial begin
        int t0, acc;
        bit ok;
        key_i   = 128'h000102030405060708090A0B0C0D0E0F;
        nonce_i = 128'h000102030405060708090A0B0C0D0E0F;
        ad_i    = 128'h000102030405060708090A0B0C0D0E0F;
        pt[0]   = 128'h000102030405060708090A0B0C0D0E0F;
        pt[1]   = 128'h101112131415161718191A1B1C1D1E1F;
        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(cipher_ready_o), 128'(0));
        chk("reset_plain", plain_o, 128'(0));
        chk("reset_outputs", 128'({plain_valid_o, busy_o, done_o, tag_ok_o}), 128'(0));
        rst = 1'b0;

        run_msg(1'b0, 0, 1'b0);   // nominal + timing
        run_msg(1'b1, 0, 1'b0);   // corrupted tag
        run_msg(1'b0, 50, 1'b0);  // back-pressure
        run_msg(1'b0, 0, 1'b1);   // start pulses while busy

        // reset during CPERM of block 1
        model_enc();
        tag_i = tag_m;
        exp_plain_q.push_back(pt[0]);
        cipher_valid_i = 1'b1;
        cipher_i = ct[0];
        start_msg(1'b0, t0, ok);
        if (ok) begin
            send_block(0, acc, ok);
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("async_reset_busy", 128'(busy_o), 128'(0));
            chk("async_reset_plain", plain_o, 128'(0));
            chk("async_reset_flags", 128'({cipher_ready_o, plain_valid_o, done_o, tag_ok_o}), 128'(0));
        end
        rst = 1'b1;
        cipher_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_done_quiet", 128'(done_o), 128'(0));
        rst = 1'b0;
        chk("reset_queue_drained", 128'(exp_plain_q.size()), 128'(0));

        // fresh message after reset, different vector
        key_i   = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        nonce_i = 128'h0123456789ABCDEFFEDCBA9876543210;
        ad_i    = 128'hDEADBEEF00000000CAFEBABE80000000;
        pt[0]   = 128'h5555AAAA5555AAAA0F0F0F0FF0F0F0F0;
        pt[1]   = 128'h00000000000000000000000000000001;
        run_msg(1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
